// File: rtl/cheri_tbre_ctrl.sv
// -----------------------------------------------------------------------------
// cheri_tbre_ctrl
//
// Sequencer for the background tag-revocation engine. Software programs an
// 8-byte-aligned [start, end) window and pulses start_i. The engine then walks
// the window one capability word at a time:
//   1. load the word through the LSU TBRE port,
//   2. wait for the revocation pipeline's verdict on that load,
//   3. if the capability is revoked, write a tag-clear back to the same address,
//   4. advance to the next word or finish.
// Only one LSU transaction is ever outstanding.
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   start_i                   start pulse (ignored while busy or while done_o)
//   stop_i                    level abort request, honoured between words
//   start_addr_i, end_addr_i  sweep window, [2:0] ignored, end exclusive
//   busy_o                    sweep in progress (any state but IDLE)
//   done_o                    one-cycle pulse after a sweep ends
//   aborted_o                 last sweep ended by stop_i
//   err_o                     sticky: LSU error seen during the current sweep
//   tbre_req_o/we_o/addr_o    LSU request (we=1 means tag-only clear write)
//   tbre_gnt_i                LSU accepted the request this cycle
//   lsu_tbre_resp_valid_i     LSU response for the outstanding request
//   lsu_tbre_resp_err_i       that response carries a bus error
//   tbre_trvk_en_i            revocation verdict valid
//   tbre_trvk_clrtag_i        loaded capability is revoked
//   scan_cnt_o, clr_cnt_o     saturating per-sweep word / clear counters
// -----------------------------------------------------------------------------
module cheri_tbre_ctrl #(
  parameter int CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,

  input  logic                start_i,
  input  logic                stop_i,
  input  logic [31:0]         start_addr_i,
  input  logic [31:0]         end_addr_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                aborted_o,
  output logic                err_o,

  output logic                tbre_req_o,
  output logic                tbre_we_o,
  output logic [31:0]         tbre_addr_o,
  input  logic                tbre_gnt_i,
  input  logic                lsu_tbre_resp_valid_i,
  input  logic                lsu_tbre_resp_err_i,

  input  logic                tbre_trvk_en_i,
  input  logic                tbre_trvk_clrtag_i,

  output logic [CntWidth-1:0] scan_cnt_o,
  output logic [CntWidth-1:0] clr_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LD_REQ    = 3'd1,
    S_LD_WAIT   = 3'd2,
    S_TRVK_WAIT = 3'd3,
    S_CLR_REQ   = 3'd4,
    S_CLR_WAIT  = 3'd5,
    S_NEXT      = 3'd6,
    S_FINISH    = 3'd7
  } state_e;

  localparam logic [CntWidth-1:0] CntOne = {{(CntWidth-1){1'b0}}, 1'b1};
  localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};

  state_e              state_q, state_d;
  // Addresses are kept as word indices (addr[31:3]); the low bits are always 0.
  logic [28:0]         cur_word_q, cur_word_d;
  logic [28:0]         end_word_q, end_word_d;
  logic                stop_seen_q, stop_seen_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;
  logic                err_q, err_d;
  logic [CntWidth-1:0] scan_cnt_q, scan_cnt_d;
  logic [CntWidth-1:0] clr_cnt_q, clr_cnt_d;

  logic                start_accept;
  logic                range_empty;
  logic [29:0]         next_word;
  logic                next_past_end;

  // done_o is high in the first IDLE cycle after FINISH; a start in that
  // cycle is deliberately dropped so software sees a clean done edge.
  assign start_accept  = (state_q == S_IDLE) && start_i && !done_q;
  assign range_empty   = (start_addr_i[31:3] >= end_addr_i[31:3]);

  // One extra bit so stepping past 0xFFFF_FFF8 cannot wrap back to 0.
  assign next_word     = {1'b0, cur_word_q} + 30'd1;
  assign next_past_end = (next_word >= {1'b0, end_word_q});

  always_comb begin
    state_d     = state_q;
    cur_word_d  = cur_word_q;
    end_word_d  = end_word_q;
    stop_seen_d = stop_seen_q;
    done_d      = 1'b0;
    aborted_d   = aborted_q;
    err_d       = err_q;
    scan_cnt_d  = scan_cnt_q;
    clr_cnt_d   = clr_cnt_q;

    // Stop is remembered from any busy cycle but only acted on in NEXT, so a
    // word already loaded always gets its verdict and, if needed, its clear.
    if ((state_q != S_IDLE) && stop_i) begin
      stop_seen_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_accept) begin
          cur_word_d  = start_addr_i[31:3];
          end_word_d  = end_addr_i[31:3];
          scan_cnt_d  = '0;
          clr_cnt_d   = '0;
          err_d       = 1'b0;
          aborted_d   = 1'b0;
          stop_seen_d = 1'b0;
          state_d     = range_empty ? S_FINISH : S_LD_REQ;
        end
      end

      S_LD_REQ: begin
        if (tbre_gnt_i) begin
          state_d = S_LD_WAIT;
        end
      end

      S_LD_WAIT: begin
        if (lsu_tbre_resp_valid_i) begin
          if (scan_cnt_q != CntMax) begin
            scan_cnt_d = scan_cnt_q + CntOne;
          end
          if (lsu_tbre_resp_err_i) begin
            err_d = 1'b1;
          end
          state_d = S_TRVK_WAIT;
        end
      end

      S_TRVK_WAIT: begin
        // The revocation stage reports clrtag=0 for an errored load, so no
        // separate error path is needed here.
        if (tbre_trvk_en_i) begin
          state_d = tbre_trvk_clrtag_i ? S_CLR_REQ : S_NEXT;
        end
      end

      S_CLR_REQ: begin
        if (tbre_gnt_i) begin
          state_d = S_CLR_WAIT;
        end
      end

      S_CLR_WAIT: begin
        if (lsu_tbre_resp_valid_i) begin
          if (lsu_tbre_resp_err_i) begin
            err_d = 1'b1;
          end else if (clr_cnt_q != CntMax) begin
            clr_cnt_d = clr_cnt_q + CntOne;
          end
          state_d = S_NEXT;
        end
      end

      S_NEXT: begin
        cur_word_d = next_word[28:0];
        if (next_past_end || stop_seen_q || stop_i) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_LD_REQ;
        end
      end

      S_FINISH: begin
        done_d    = 1'b1;
        aborted_d = stop_seen_q | stop_i;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cur_word_q  <= '0;
      end_word_q  <= '0;
      stop_seen_q <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      err_q       <= 1'b0;
      scan_cnt_q  <= '0;
      clr_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_word_q  <= cur_word_d;
      end_word_q  <= end_word_d;
      stop_seen_q <= stop_seen_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      err_q       <= err_d;
      scan_cnt_q  <= scan_cnt_d;
      clr_cnt_q   <= clr_cnt_d;
    end
  end

  // Request outputs decode straight from the state register; the address
  // register only moves in NEXT, so req/we/addr hold steady until grant.
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign aborted_o   = aborted_q;
  assign err_o       = err_q;
  assign tbre_req_o  = (state_q == S_LD_REQ) || (state_q == S_CLR_REQ);
  assign tbre_we_o   = (state_q == S_CLR_REQ);
  assign tbre_addr_o = {cur_word_q, 3'b000};
  assign scan_cnt_o  = scan_cnt_q;
  assign clr_cnt_o   = clr_cnt_q;

endmodule

// File: tb/tb_cheri_tbre_ctrl.sv
// -----------------------------------------------------------------------------
// Directed testbench for cheri_tbre_ctrl. A small LSU / revocation-stage model
// runs once per negative edge from the main process: zero-wait grant (unless a
// stall is programmed), response the cycle after grant, verdict three cycles
// after a load response.
// -----------------------------------------------------------------------------
module tb_cheri_tbre_ctrl;

  localparam int CW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic          stop_i;
  logic [31:0]   start_addr_i;
  logic [31:0]   end_addr_i;
  logic          busy_o;
  logic          done_o;
  logic          aborted_o;
  logic          err_o;
  logic          tbre_req_o;
  logic          tbre_we_o;
  logic [31:0]   tbre_addr_o;
  logic          tbre_gnt_i;
  logic          lsu_tbre_resp_valid_i;
  logic          lsu_tbre_resp_err_i;
  logic          tbre_trvk_en_i;
  logic          tbre_trvk_clrtag_i;
  logic [CW-1:0] scan_cnt_o;
  logic [CW-1:0] clr_cnt_o;

  always #5 clk_i = ~clk_i;

  cheri_tbre_ctrl #(.CntWidth(CW)) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .start_i               (start_i),
    .stop_i                (stop_i),
    .start_addr_i          (start_addr_i),
    .end_addr_i            (end_addr_i),
    .busy_o                (busy_o),
    .done_o                (done_o),
    .aborted_o             (aborted_o),
    .err_o                 (err_o),
    .tbre_req_o            (tbre_req_o),
    .tbre_we_o             (tbre_we_o),
    .tbre_addr_o           (tbre_addr_o),
    .tbre_gnt_i            (tbre_gnt_i),
    .lsu_tbre_resp_valid_i (lsu_tbre_resp_valid_i),
    .lsu_tbre_resp_err_i   (lsu_tbre_resp_err_i),
    .tbre_trvk_en_i        (tbre_trvk_en_i),
    .tbre_trvk_clrtag_i    (tbre_trvk_clrtag_i),
    .scan_cnt_o            (scan_cnt_o),
    .clr_cnt_o             (clr_cnt_o)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // model configuration
  bit          rvk_en;
  logic [31:0] rvk_addr;
  bit          err_en;
  bit          err_we;
  logic [31:0] err_addr;
  bit          stop_en;
  logic [31:0] stop_addr;
  int          hold_left;

  // model state
  bit          resp_pend;
  bit          pend_we;
  logic [31:0] pend_addr;
  int          trvk_cnt;
  bit          trvk_clr;
  bit          trvk_stop;
  bit          req_active;
  bit          req_we;
  logic [31:0] req_addr;
  int          req_first;
  int          unstable;

  // granted transactions
  logic [31:0] log_addr[$];
  bit          log_we[$];
  int          log_cyc[$];

  // per-sweep observations
  int r_done_cnt;
  int r_start_cyc;
  int r_done_cyc;
  bit r_busy_at_done;
  bit r_busy_after;
  bit busy_hist[8];

  task automatic model_clear();
    rvk_en = 0; rvk_addr = '0; err_en = 0; err_we = 0; err_addr = '0;
    stop_en = 0; stop_addr = '0; hold_left = 0;
    resp_pend = 0; pend_we = 0; pend_addr = '0; trvk_cnt = 0; trvk_clr = 0;
    trvk_stop = 0; req_active = 0; req_we = 0; req_addr = '0; req_first = 0;
    unstable = 0;
    log_addr.delete(); log_we.delete(); log_cyc.delete();
  endtask

  task automatic lsu_step();
    tbre_gnt_i            = 1'b0;
    lsu_tbre_resp_valid_i = 1'b0;
    lsu_tbre_resp_err_i   = 1'b0;
    tbre_trvk_en_i        = 1'b0;
    tbre_trvk_clrtag_i    = 1'b0;
    if (done_o === 1'b1) stop_i = 1'b0;
    if (resp_pend) begin
      resp_pend = 0;
      lsu_tbre_resp_valid_i = 1'b1;
      lsu_tbre_resp_err_i   = err_en && (pend_addr == err_addr) && (pend_we == err_we);
      if (!pend_we) begin
        trvk_cnt  = 3;
        trvk_clr  = rvk_en && (pend_addr == rvk_addr) && !lsu_tbre_resp_err_i;
        trvk_stop = stop_en && (pend_addr == stop_addr);
      end
    end else if (trvk_cnt > 0) begin
      trvk_cnt--;
      if (trvk_stop) begin
        stop_i    = 1'b1;
        trvk_stop = 0;
      end
      if (trvk_cnt == 0) begin
        tbre_trvk_en_i     = 1'b1;
        tbre_trvk_clrtag_i = trvk_clr;
      end
    end
    if (tbre_req_o === 1'b1) begin
      if (!req_active) begin
        req_active = 1;
        req_we     = tbre_we_o;
        req_addr   = tbre_addr_o;
        req_first  = cyc;
      end else if (tbre_we_o !== req_we || tbre_addr_o !== req_addr) begin
        unstable++;
      end
      if (hold_left > 0) begin
        hold_left--;
      end else begin
        tbre_gnt_i = 1'b1;
        resp_pend  = 1;
        pend_we    = tbre_we_o;
        pend_addr  = tbre_addr_o;
        log_addr.push_back(tbre_addr_o);
        log_we.push_back(tbre_we_o);
        log_cyc.push_back(req_first);
        req_active = 0;
      end
    end else if (req_active) begin
      unstable++;  // request withdrawn before grant
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    cyc++;
    lsu_step();
  endtask

  // Start a sweep, optionally poke start_i while done_o is high, and run until
  // three cycles after the first done_o or a 300-cycle budget.
  task automatic run_sweep(input logic [31:0] sa, input logic [31:0] ea, input bit poke);
    start_addr_i = sa;
    end_addr_i   = ea;
    for (int i = 0; i < 8; i++) busy_hist[i] = 0;
    r_done_cnt = 0; r_done_cyc = -1; r_busy_at_done = 1; r_busy_after = 1;
    tick();
    start_i     = 1'b1;
    r_start_cyc = cyc;
    busy_hist[0] = busy_o;
    for (int i = 0; i < 300; i++) begin
      tick();
      start_i = 1'b0;
      if (cyc - r_start_cyc < 8) busy_hist[cyc - r_start_cyc] = busy_o;
      if (r_done_cyc >= 0 && cyc == r_done_cyc + 1) r_busy_after = busy_o;
      if (done_o === 1'b1) begin
        r_done_cnt++;
        if (r_done_cyc < 0) begin
          r_done_cyc     = cyc;
          r_busy_at_done = busy_o;
          if (poke) start_i = 1'b1;
        end
      end
      if (r_done_cyc >= 0 && cyc >= r_done_cyc + 3) break;
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0;
    start_addr_i = 32'h2000_0000; end_addr_i = 32'h2000_0020;
    model_clear();
    tick(); tick(); tick();
    checks++;
    if ({busy_o, done_o, aborted_o, err_o, tbre_req_o, tbre_we_o} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000000", {busy_o, done_o, aborted_o, err_o, tbre_req_o, tbre_we_o});
    end
    checks++;
    if (tbre_addr_o !== 32'h0) begin
      failures++; $display("FAIL reset_addr got=%h exp=00000000", tbre_addr_o);
    end
    checks++;
    if (scan_cnt_o !== '0 || clr_cnt_o !== '0) begin
      failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", scan_cnt_o, clr_cnt_o);
    end
    rst_i = 1'b0;
    tick();
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_basic();
    model_clear();
    run_sweep(32'h2000_0000, 32'h2000_0020, 1'b1);
    checks++;
    if (r_done_cnt !== 1) begin
      failures++; $display("FAIL basic_done_cnt got=%0d exp=1", r_done_cnt);
    end
    checks++;
    if (log_addr.size() !== 4) begin
      failures++; $display("FAIL basic_num_req got=%0d exp=4", log_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (log_addr[i] !== 32'h2000_0000 + 32'(8 * i) || log_we[i] !== 1'b0) begin
          failures++;
          $display("FAIL basic_req%0d got=%h/we%0b exp=%h/we0", i, log_addr[i], log_we[i], 32'h2000_0000 + 32'(8 * i));
        end
      end
      checks++;
      if (log_cyc[0] - r_start_cyc !== 1 || log_cyc[1] - log_cyc[0] !== 6) begin
        failures++;
        $display("FAIL basic_latency got=%0d,%0d exp=1,6", log_cyc[0] - r_start_cyc, log_cyc[1] - log_cyc[0]);
      end
    end
    checks++;
    if (r_done_cyc - r_start_cyc !== 26) begin
      failures++; $display("FAIL basic_done_time got=%0d exp=26", r_done_cyc - r_start_cyc);
    end
    checks++;
    if (scan_cnt_o !== 16'd4 || clr_cnt_o !== 16'd0 || aborted_o !== 1'b0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_status got=scan%0d clr%0d ab%0b err%0b exp=scan4 clr0 ab0 err0", scan_cnt_o, clr_cnt_o, aborted_o, err_o);
    end
    checks++;
    if (r_busy_at_done !== 1'b0 || r_busy_after !== 1'b0) begin
      failures++;
      $display("FAIL basic_start_on_done got=busy%0b,%0b exp=busy0,0", r_busy_at_done, r_busy_after);
    end
    $display("test_basic done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_revoke();
    logic [31:0] exp_addr[5];
    bit          exp_we[5];
    exp_addr = '{32'h2000_0000, 32'h2000_0008, 32'h2000_0008, 32'h2000_0010, 32'h2000_0018};
    exp_we   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    model_clear();
    rvk_en = 1; rvk_addr = 32'h2000_0008;
    run_sweep(32'h2000_0000, 32'h2000_0020, 1'b0);
    checks++;
    if (log_addr.size() !== 5) begin
      failures++; $display("FAIL revoke_num_req got=%0d exp=5", log_addr.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (log_addr[i] !== exp_addr[i] || log_we[i] !== exp_we[i]) begin
          failures++;
          $display("FAIL revoke_req%0d got=%h/we%0b exp=%h/we%0b", i, log_addr[i], log_we[i], exp_addr[i], exp_we[i]);
        end
      end
      checks++;
      if (log_cyc[2] - log_cyc[1] !== 5 || log_cyc[3] - log_cyc[2] !== 3) begin
        failures++;
        $display("FAIL revoke_latency got=%0d,%0d exp=5,3", log_cyc[2] - log_cyc[1], log_cyc[3] - log_cyc[2]);
      end
    end
    checks++;
    if (scan_cnt_o !== 16'd4 || clr_cnt_o !== 16'd1 || r_done_cnt !== 1) begin
      failures++;
      $display("FAIL revoke_status got=scan%0d clr%0d done%0d exp=scan4 clr1 done1", scan_cnt_o, clr_cnt_o, r_done_cnt);
    end
    $display("test_revoke done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_err();
    // load error on the 3rd word: no clear, sweep continues
    model_clear();
    rvk_en = 1; rvk_addr = 32'h2000_0010;
    err_en = 1; err_we = 0; err_addr = 32'h2000_0010;
    run_sweep(32'h2000_0000, 32'h2000_0020, 1'b0);
    checks++;
    if (log_addr.size() !== 4 || log_we.sum() !== 0) begin
      failures++; $display("FAIL err_load_reqs got=%0d exp=4 loads only", log_addr.size());
    end
    checks++;
    if (err_o !== 1'b1 || scan_cnt_o !== 16'd4 || clr_cnt_o !== 16'd0 || r_done_cnt !== 1) begin
      failures++;
      $display("FAIL err_load_status got=err%0b scan%0d clr%0d done%0d exp=err1 scan4 clr0 done1", err_o, scan_cnt_o, clr_cnt_o, r_done_cnt);
    end
    // error on the clear write: clear not counted
    model_clear();
    rvk_en = 1; rvk_addr = 32'h2000_0008;
    err_en = 1; err_we = 1; err_addr = 32'h2000_0008;
    run_sweep(32'h2000_0000, 32'h2000_0020, 1'b0);
    checks++;
    if (log_addr.size() !== 5 || err_o !== 1'b1 || clr_cnt_o !== 16'd0 || scan_cnt_o !== 16'd4) begin
      failures++;
      $display("FAIL err_clr_status got=req%0d err%0b clr%0d scan%0d exp=req5 err1 clr0 scan4", log_addr.size(), err_o, clr_cnt_o, scan_cnt_o);
    end
    $display("test_err done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_stop();
    model_clear();
    rvk_en = 1; rvk_addr = 32'h2000_0008;
    stop_en = 1; stop_addr = 32'h2000_0008;
    run_sweep(32'h2000_0000, 32'h2000_0020, 1'b0);
    checks++;
    if (log_addr.size() !== 3) begin
      failures++; $display("FAIL stop_num_req got=%0d exp=3", log_addr.size());
    end else begin
      checks++;
      if (log_addr[2] !== 32'h2000_0008 || log_we[2] !== 1'b1) begin
        failures++; $display("FAIL stop_clear got=%h/we%0b exp=20000008/we1", log_addr[2], log_we[2]);
      end
    end
    checks++;
    if (aborted_o !== 1'b1 || scan_cnt_o !== 16'd2 || clr_cnt_o !== 16'd1 || err_o !== 1'b0 || r_done_cnt !== 1) begin
      failures++;
      $display("FAIL stop_status got=ab%0b scan%0d clr%0d err%0b done%0d exp=ab1 scan2 clr1 err0 done1", aborted_o, scan_cnt_o, clr_cnt_o, err_o, r_done_cnt);
    end
    $display("test_stop done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_empty();
    model_clear();
    run_sweep(32'h0000_0100, 32'h0000_0100, 1'b0);
    checks++;
    if (log_addr.size() !== 0 || r_done_cyc - r_start_cyc !== 2 || r_done_cnt !== 1) begin
      failures++;
      $display("FAIL empty_eq got=req%0d done_at%0d cnt%0d exp=req0 done_at2 cnt1", log_addr.size(), r_done_cyc - r_start_cyc, r_done_cnt);
    end
    checks++;
    if ({busy_hist[0], busy_hist[1], busy_hist[2]} !== 3'b010) begin
      failures++;
      $display("FAIL empty_busy got=%b%b%b exp=010", busy_hist[0], busy_hist[1], busy_hist[2]);
    end
    checks++;
    if (aborted_o !== 1'b0 || scan_cnt_o !== 16'd0 || clr_cnt_o !== 16'd0) begin
      failures++;
      $display("FAIL empty_status got=ab%0b scan%0d clr%0d exp=ab0 scan0 clr0", aborted_o, scan_cnt_o, clr_cnt_o);
    end
    model_clear();
    run_sweep(32'h0000_0108, 32'h0000_0100, 1'b0);
    checks++;
    if (log_addr.size() !== 0 || r_done_cyc - r_start_cyc !== 2 || r_done_cnt !== 1) begin
      failures++;
      $display("FAIL empty_gt got=req%0d done_at%0d cnt%0d exp=req0 done_at2 cnt1", log_addr.size(), r_done_cyc - r_start_cyc, r_done_cnt);
    end
    $display("test_empty done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_top_stall_reset();
    int late_done;
    model_clear();
    hold_left = 5;
    run_sweep(32'hFFFF_FFE8, 32'hFFFF_FFF8, 1'b0);
    checks++;
    if (log_addr.size() !== 2) begin
      failures++; $display("FAIL top_num_req got=%0d exp=2", log_addr.size());
    end else begin
      checks++;
      if (log_addr[0] !== 32'hFFFF_FFE8 || log_addr[1] !== 32'hFFFF_FFF0 || log_we[0] !== 1'b0 || log_we[1] !== 1'b0) begin
        failures++; $display("FAIL top_addrs got=%h,%h exp=ffffffe8,fffffff0", log_addr[0], log_addr[1]);
      end
      checks++;
      if (log_cyc[0] - r_start_cyc !== 1 || log_cyc[1] - log_cyc[0] !== 11) begin
        failures++;
        $display("FAIL top_stall_timing got=%0d,%0d exp=1,11", log_cyc[0] - r_start_cyc, log_cyc[1] - log_cyc[0]);
      end
    end
    checks++;
    if (unstable !== 0 || scan_cnt_o !== 16'd2 || r_done_cnt !== 1) begin
      failures++;
      $display("FAIL top_status got=unstable%0d scan%0d done%0d exp=unstable0 scan2 done1", unstable, scan_cnt_o, r_done_cnt);
    end
    // rerun and reset in the middle of the first verdict wait
    model_clear();
    start_addr_i = 32'hFFFF_FFE8; end_addr_i = 32'hFFFF_FFF8;
    tick(); start_i = 1'b1;
    tick(); start_i = 1'b0;
    tick(); tick();
    checks++;
    if (busy_o !== 1'b1) begin
      failures++; $display("FAIL rerun_busy got=%0b exp=1", busy_o);
    end
    rst_i = 1'b1;
    model_clear();
    tick();
    checks++;
    if ({busy_o, done_o, aborted_o, err_o, tbre_req_o, tbre_we_o} !== 6'b0 || tbre_addr_o !== 32'h0
        || scan_cnt_o !== '0 || clr_cnt_o !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got=%b addr=%h scan%0d clr%0d exp=000000 addr=0 scan0 clr0",
               {busy_o, done_o, aborted_o, err_o, tbre_req_o, tbre_we_o}, tbre_addr_o, scan_cnt_o, clr_cnt_o);
    end
    rst_i = 1'b0;
    late_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done_o === 1'b1 || busy_o === 1'b1 || tbre_req_o === 1'b1) late_done++;
    end
    checks++;
    if (late_done !== 0) begin
      failures++; $display("FAIL midreset_quiet got=%0d active cycles exp=0", late_done);
    end
    $display("test_top_stall_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_revoke();
    test_err();
    test_stop();
    test_empty();
    test_top_stall_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
